// File: rtl/haz_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package haz_pkg;

    typedef enum logic [0:0] {
        StRun = 1'b0,
        StIsr = 1'b1
    } haz_state_e;

    // Forwarding select value meaning "read the register file".
    localparam int unsigned FWD_RF = 0;

endpackage

// File: rtl/haz_fwd_sel.sv
// Nearest-producer priority encoder for one ID-stage source operand.
module haz_fwd_sel
    import haz_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned FWD_STAGES = 3
) (
    input  logic [REG_AW-1:0]              addr,
    input  logic                           used,
    input  logic [FWD_STAGES-1:0]          prod_wen,
    input  logic [FWD_STAGES*REG_AW-1:0]   prod_addr,
    input  logic [FWD_STAGES-1:0]          prod_is_load,
    output logic [$clog2(FWD_STAGES+1)-1:0] sel,
    output logic                           is_load
);

    localparam int unsigned SelW = $clog2(FWD_STAGES + 1);

    // Scan from the farthest stage inward so the nearest match overwrites.
    always_comb begin
        sel     = SelW'(FWD_RF);
        is_load = 1'b0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (used && (addr != '0) && prod_wen[k] &&
                (prod_addr[k*REG_AW +: REG_AW] == addr)) begin
                sel     = SelW'(k + 1);
                is_load = prod_is_load[k];
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Forwarding, load-use stall, flush and interrupt/ERET sequencing beside ID.
// HAZ_PERF_CNT_EN adds stall_cnt/flush_cnt performance counters.
module pipe_hazard_unit
    import haz_pkg::*;
#(
    parameter int unsigned REG_AW           = 5,
    parameter int unsigned FWD_STAGES       = 3,
    parameter int unsigned LOAD_READY_STAGE = 2,
    parameter int unsigned CNT_W            = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [REG_AW-1:0]               rs_addr,
    input  logic [REG_AW-1:0]               rt_addr,
    input  logic                            rs_used,
    input  logic                            rt_used,
    input  logic [FWD_STAGES-1:0]           prod_wen,
    input  logic [FWD_STAGES*REG_AW-1:0]    prod_addr,
    input  logic [FWD_STAGES-1:0]           prod_is_load,
    input  logic                            redirect,
    input  logic                            irq_req,
    input  logic                            eret_id,
    output logic [$clog2(FWD_STAGES+1)-1:0] fwd_a,
    output logic [$clog2(FWD_STAGES+1)-1:0] fwd_b,
    output logic                            if_en,
    output logic                            id_en,
    output logic                            id_flush,
    output logic                            exe_flush,
    output logic                            irq_take,
    output logic                            eret_take,
    output logic                            in_isr
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]                stall_cnt,
    output logic [CNT_W-1:0]                flush_cnt
`endif
);

    localparam int unsigned SelW = $clog2(FWD_STAGES + 1);

    logic [SelW-1:0] sel_a, sel_b;
    logic            load_a, load_b;
    logic            stall;
    haz_state_e      state_q, state_d;

    haz_fwd_sel #(
        .REG_AW     (REG_AW),
        .FWD_STAGES (FWD_STAGES)
    ) u_fwd_a (
        .addr         (rs_addr),
        .used         (rs_used),
        .prod_wen     (prod_wen),
        .prod_addr    (prod_addr),
        .prod_is_load (prod_is_load),
        .sel          (sel_a),
        .is_load      (load_a)
    );

    haz_fwd_sel #(
        .REG_AW     (REG_AW),
        .FWD_STAGES (FWD_STAGES)
    ) u_fwd_b (
        .addr         (rt_addr),
        .used         (rt_used),
        .prod_wen     (prod_wen),
        .prod_addr    (prod_addr),
        .prod_is_load (prod_is_load),
        .sel          (sel_b),
        .is_load      (load_b)
    );

    // A matched load is only a hazard while it sits before the ready stage.
    assign stall = (load_a && (32'(sel_a) < LOAD_READY_STAGE)) ||
                   (load_b && (32'(sel_b) < LOAD_READY_STAGE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        fwd_a     = sel_a;
        fwd_b     = sel_b;
        if_en     = 1'b1;
        id_en     = 1'b1;
        id_flush  = 1'b0;
        exe_flush = 1'b0;
        irq_take  = 1'b0;
        eret_take = 1'b0;
        if (!rst_n) begin
            fwd_a     = SelW'(FWD_RF);
            fwd_b     = SelW'(FWD_RF);
            if_en     = 1'b0;
            id_en     = 1'b0;
            id_flush  = 1'b1;
            exe_flush = 1'b1;
        end else if (stall) begin
            fwd_a     = SelW'(FWD_RF);
            fwd_b     = SelW'(FWD_RF);
            if_en     = 1'b0;
            id_en     = 1'b0;
            exe_flush = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    // EPC is the ID PC, so a coincident branch re-executes after ERET.
                    if (irq_req) begin
                        irq_take = 1'b1;
                        id_flush = 1'b1;
                        state_d  = StIsr;
                    end else if (redirect) begin
                        id_flush = 1'b1;
                    end
                end
                StIsr: begin
                    if (eret_id) begin
                        eret_take = 1'b1;
                        id_flush  = 1'b1;
                        state_d   = StRun;
                    end else if (redirect) begin
                        id_flush = 1'b1;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    assign in_isr = (state_q == StIsr);

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (id_flush) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // Counter width only matters when the counters are built.
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule
